// File: rtl/pic_fetch_ctrl.sv
// Picture ROM fetch sequencer: places a PIC_W x PIC_H window at a runtime (x0,y0), issues
// rom_addr/rom_rden one pixel early and flags aligned ROM data; position changes land at frame start.
module pic_fetch_ctrl #(
  parameter int H_VALID = 640,
  parameter int V_VALID = 480,
  parameter int PIC_W   = 600,
  parameter int PIC_H   = 100,
  parameter int ADDR_W  = 16
) (
  input  logic              i_vga_clk,
  input  logic              i_sys_rst_n,
  input  logic [9:0]        i_pix_x,
  input  logic [9:0]        i_pix_y,
  input  logic              i_frame_start,
  input  logic              i_cfg_en,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [9:0]        i_cfg_x0,
  input  logic [9:0]        i_cfg_y0,
  output logic              o_cfg_err,
  output logic [ADDR_W-1:0] o_rom_addr,
  output logic              o_rom_rden,
  output logic              o_pic_valid,
  output logic              o_frame_done,
  output logic [1:0]        o_ctrl_state
);

  localparam logic [10:0]       X_MAX     = 11'(H_VALID - PIC_W);
  localparam logic [10:0]       Y_MAX     = 11'(V_VALID - PIC_H);
  localparam logic [9:0]        X_RST     = 10'((H_VALID - PIC_W) / 2);
  localparam logic [9:0]        Y_RST     = 10'((V_VALID - PIC_H) / 2);
  localparam logic [10:0]       W11       = 11'(PIC_W);
  localparam logic [10:0]       H11       = 11'(PIC_H);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIC_W * PIC_H - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [9:0]  r_x0;
  logic [9:0]  r_y0;
  logic [9:0]  r_pend_x;
  logic [9:0]  r_pend_y;
  logic        r_pend;

  logic        w_xfer;
  logic        w_legal;
  logic [10:0] w_x_lo;
  logic [10:0] w_x_hi;
  logic [10:0] w_y_hi;
  logic        w_in_win;
  logic        w_rden;

  assign w_xfer  = i_cfg_valid && o_cfg_ready;
  assign w_legal = (i_cfg_x0 != 10'd0) && ({1'b0, i_cfg_x0} <= X_MAX) &&
                   ({1'b0, i_cfg_y0} <= Y_MAX);

  // Left edge starts one column early so ROM q lines up with the pixel it belongs to.
  assign w_x_lo   = {1'b0, r_x0} - 11'd1;
  assign w_x_hi   = {1'b0, r_x0} + W11 - 11'd1;
  assign w_y_hi   = {1'b0, r_y0} + H11;
  assign w_in_win = ({1'b0, i_pix_x} >= w_x_lo) && ({1'b0, i_pix_x} < w_x_hi) &&
                    ({1'b0, i_pix_y} >= {1'b0, r_y0}) && ({1'b0, i_pix_y} < w_y_hi);
  assign w_rden   = (r_state == ACTIVE) && w_in_win;

  assign o_rom_rden   = w_rden;
  assign o_ctrl_state = r_state;

  // A pending position is held back until the next frame start so a frame never tears.
  always_ff @(posedge i_vga_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_x0        <= X_RST;
      r_y0        <= Y_RST;
      r_pend_x    <= 10'd0;
      r_pend_y    <= 10'd0;
      r_pend      <= 1'b0;
      o_cfg_ready <= 1'b1;
      o_cfg_err   <= 1'b0;
    end else begin
      o_cfg_err <= w_xfer && !w_legal;
      if (i_frame_start && r_pend) begin
        r_x0        <= r_pend_x;
        r_y0        <= r_pend_y;
        r_pend      <= 1'b0;
        o_cfg_ready <= 1'b1;
      end
      if (w_xfer && w_legal) begin
        r_pend_x    <= i_cfg_x0;
        r_pend_y    <= i_cfg_y0;
        r_pend      <= 1'b1;
        o_cfg_ready <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_vga_clk or negedge i_sys_rst_n) begin
    if (!i_sys_rst_n) begin
      r_state      <= IDLE;
      o_rom_addr   <= '0;
      o_pic_valid  <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_pic_valid  <= w_rden;
      o_frame_done <= 1'b0;
      if (i_frame_start) begin
        o_rom_addr <= '0;
        r_state    <= i_cfg_en ? ACTIVE : IDLE;
      end else if (w_rden) begin
        if (o_rom_addr == LAST_ADDR) begin
          o_rom_addr   <= '0;
          o_frame_done <= 1'b1;
          r_state      <= DONE;
        end else begin
          o_rom_addr <= o_rom_addr + ADDR_W'(1);
        end
      end
    end
  end

endmodule
